op_datapath: RTL



---
 rtl/op_datapath_pkg.sv | 60 ++++++
 rtl/op_datapath_alu.sv | 51 +++++
 rtl/op_datapath.sv | 124 ++++++++++++
 3 files changed

// File: rtl/op_datapath_pkg.sv
// -----------------------------------------------------------------------------
// op_datapath_pkg
// Shared definitions for the operational datapath:
//   - default widths and the counter terminal value
//   - A-register write-select encoding
//   - fixed priority order of the A writers and a helper that applies it
// -----------------------------------------------------------------------------
package op_datapath_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_CNT_MAX = 7;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_SHL  = 3'd1,
        SEL_ADD  = 3'd2,
        SEL_SUB  = 3'd3,
        SEL_LOAD = 3'd4
    } a_sel_e;

    localparam int N_A_WRITERS = 4;

    // Highest priority first: t5 (load) > t9 (sub) > t1 (add) > t2 (shift).
    localparam a_sel_e A_PRIO [N_A_WRITERS] = '{SEL_LOAD, SEL_SUB, SEL_ADD, SEL_SHL};

    function automatic logic sel_requested(input a_sel_e sel,
                                           input logic   t5,
                                           input logic   t9,
                                           input logic   t1,
                                           input logic   t2);
        logic req;
        req = 1'b0;
        case (sel)
            SEL_LOAD: req = t5;
            SEL_SUB:  req = t9;
            SEL_ADD:  req = t1;
            SEL_SHL:  req = t2;
            default:  req = 1'b0;
        endcase
        return req;
    endfunction

    // Walk the priority list from lowest to highest so the highest-priority
    // active request is the last one written.
    function automatic a_sel_e pick_a_sel(input logic t5,
                                          input logic t9,
                                          input logic t1,
                                          input logic t2);
        a_sel_e sel;
        sel = SEL_NONE;
        for (int i = N_A_WRITERS - 1; i >= 0; i--) begin
            if (sel_requested(A_PRIO[i], t5, t9, t1, t2)) begin
                sel = A_PRIO[i];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/op_datapath_alu.sv
// -----------------------------------------------------------------------------
// op_alu
// Combinational W-bit arithmetic unit for the A register.
// Ports:
//   a, b     in   W   operands (A register, B register)
//   sel      in   3   operation select (SEL_ADD / SEL_SUB / SEL_SHL; others pass a)
//   result   out  W   operation result, modulo 2^W
//   ovf_bit  out  1   carry-out (add), borrow (sub) or shifted-out MSB (shift)
// -----------------------------------------------------------------------------
module op_alu
    import op_datapath_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  a_sel_e       sel,
    output logic [W-1:0] result,
    output logic         ovf_bit
);

    logic [W:0] wide;

    always_comb begin
        wide    = '0;
        result  = a;
        ovf_bit = 1'b0;
        case (sel)
            SEL_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                result  = wide[W-1:0];
                ovf_bit = wide[W];
            end
            SEL_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                wide    = {1'b0, a} - {1'b0, b};
                result  = wide[W-1:0];
                ovf_bit = wide[W];
            end
            SEL_SHL: begin
                result  = {a[W-2:0], 1'b0};
                ovf_bit = a[W-1];
            end
            default: begin
                result  = a;
                ovf_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/op_datapath.sv
// -----------------------------------------------------------------------------
// op_datapath
// Operational datapath executing one set of microoperation strobes per clock
// and returning the condition signals the control automaton branches on.
// Ports:
//   clk       in   1      rising-edge clock
//   res       in   1      synchronous active-low reset
//   din       in   W      external operand bus
//   t1        in   1      A <= A + B
//   t2        in   1      A <= A << 1
//   t4        in   1      B <= din
//   t5        in   1      A <= din, clears ovf
//   t6        in   1      cnt <= 0
//   t7        in   1      cnt <= cnt + 1
//   t8        in   1      dout <= A, pulse dout_vld
//   t9        in   1      A <= A - B
//   x         out  1      A == 0
//   y         out  1      cnt == CNT_MAX
//   dout      out  W      result register
//   dout_vld  out  1      one-cycle result-valid pulse
//   ovf       out  1      sticky arithmetic overflow
// -----------------------------------------------------------------------------
module op_datapath
    import op_datapath_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic         clk,
    input  logic         res,
    input  logic [W-1:0] din,
    input  logic         t1,
    input  logic         t2,
    input  logic         t4,
    input  logic         t5,
    input  logic         t6,
    input  logic         t7,
    input  logic         t8,
    input  logic         t9,
    output logic         x,
    output logic         y,
    output logic [W-1:0] dout,
    output logic         dout_vld,
    output logic         ovf
);

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [CNT_W-1:0] cnt_q;

    a_sel_e           a_sel;
    logic [W-1:0]     alu_res;
    logic             alu_ovf;
    logic [W-1:0]     a_d;
    logic             ovf_d;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        a_sel = pick_a_sel(t5, t9, t1, t2);
    end

    // B is read before its own update, so a t4 in the same cycle as t1/t9
    // leaves the arithmetic on the old operand.
    op_alu #(
        .W (W)
    ) u_alu (
        .a       (a_q),
        .b       (b_q),
        .sel     (a_sel),
        .result  (alu_res),
        .ovf_bit (alu_ovf)
    );

    always_comb begin
        a_d   = a_q;
        ovf_d = ovf;
        if (a_sel == SEL_LOAD) begin
            a_d   = din;
            ovf_d = 1'b0;
        end else if (a_sel != SEL_NONE) begin
            a_d   = alu_res;
            ovf_d = ovf | alu_ovf;
        end
    end

    // Counter wraps naturally at 2^CNT_W; the wrap never touches ovf.
    always_comb begin
        cnt_d = cnt_q;
        if (t6) begin
            cnt_d = '0;
        end else if (t7) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            ovf      <= ovf_d;
            dout_vld <= t8;
            if (t4) begin
                b_q <= din;
            end
            // Captures A as it stands during the t8 cycle, before any update.
            if (t8) begin
                dout <= a_q;
            end
        end
    end

    // Decodes of registered state only: no path from the strobes to x/y.
    assign x = (a_q == '0);
    assign y = (cnt_q == CNT_W'(CNT_MAX));

endmodule
